// File: rtl/ux607_uart0_rx_ctrl_if.sv
// FIFO read port between the UART0 receive controller and its consumer.
// The consumer (master) issues pops; the controller (slave) presents the head entry.
interface ux607_uart0_rx_ctrl_if;
  logic       rd_req;
  logic [8:0] rd_data;
  logic       rd_valid;

  modport master (output rd_req, input rd_data, input rd_valid);
  modport slave  (input rd_req, output rd_data, output rd_valid);
endinterface

// File: rtl/ux607_uart0_rx_ctrl.sv
// UART0 receive controller: sample-tick generator, capture FSM, 4-entry RX FIFO and interrupts.
// Optional timeout interrupt is compiled in with macro UX607_UART_RX_TIMEOUT_EN.
module ux607_uart0_rx_ctrl (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_en,
  input  logic                        cfg_no_parity,
  input  logic                        cfg_ev_parity,
  input  logic [15:0]                 cfg_div,
  input  logic [2:0]                  cfg_thresh,
  input  logic                        rx_ok,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_perr,
  output logic                        rx_en,
  output logic                        rx_data_sample,
  output logic                        no_parity,
  output logic                        ev_parity,
  output logic                        rd_data_flag,
  ux607_uart0_rx_ctrl_if.slave        rd,
  output logic [2:0]                  fifo_cnt,
  output logic                        ovr,
  input  logic                        ovr_clr,
  output logic                        irq_lvl,
  output logic                        irq_tmo
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_WAIT_OK  = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_WAIT_CLR = 2'd3
  } state_t;

  state_t      state_r;
  logic        rx_en_r;
  logic        rd_data_flag_r;
  logic        no_parity_r;
  logic        ev_parity_r;

  logic [15:0] tick_cnt_r;
  logic        sample_s;

  logic [8:0]  mem_r [0:3];
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_nxt_s;
  logic        ovr_r;
  logic        irq_lvl_r;

  logic        push_s;
  logic        pop_s;
  logic        full_s;
  logic        wr_s;
  logic        ovr_set_s;
  logic [2:0]  thr_s;

  // Sample-tick counter: free-runs 0..cfg_div while enabled, parked at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= 16'd0;
    end else if (!cfg_en) begin
      tick_cnt_r <= 16'd0;
    end else if (tick_cnt_r == cfg_div) begin
      tick_cnt_r <= 16'd0;
    end else begin
      tick_cnt_r <= tick_cnt_r + 16'd1;
    end
  end

  // Pulse is gated by rst/cfg_en so no tick escapes while disabled or in reset.
  assign sample_s       = cfg_en & ~rst & (tick_cnt_r == cfg_div);
  assign rx_data_sample = sample_s;

  // Capture FSM with registered receiver controls; parity config is latched only while OFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_OFF;
      rx_en_r        <= 1'b0;
      rd_data_flag_r <= 1'b0;
      no_parity_r    <= 1'b0;
      ev_parity_r    <= 1'b0;
    end else if (!cfg_en) begin
      state_r        <= ST_OFF;
      rx_en_r        <= 1'b0;
      rd_data_flag_r <= 1'b0;
      if (state_r == ST_OFF) begin
        no_parity_r <= cfg_no_parity;
        ev_parity_r <= cfg_ev_parity;
      end
    end else begin
      case (state_r)
        ST_OFF: begin
          state_r        <= ST_WAIT_OK;
          rx_en_r        <= 1'b1;
          rd_data_flag_r <= 1'b0;
          no_parity_r    <= cfg_no_parity;
          ev_parity_r    <= cfg_ev_parity;
        end
        ST_WAIT_OK: begin
          if (rx_ok) begin
            state_r        <= ST_CAPTURE;
            rd_data_flag_r <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          state_r        <= ST_WAIT_CLR;
          rd_data_flag_r <= 1'b0;
        end
        ST_WAIT_CLR: begin
          if (!rx_ok) begin
            state_r <= ST_WAIT_OK;
          end
        end
        default: begin
          state_r        <= ST_OFF;
          rx_en_r        <= 1'b0;
          rd_data_flag_r <= 1'b0;
        end
      endcase
    end
  end

  assign rx_en        = rx_en_r;
  assign rd_data_flag = rd_data_flag_r;
  assign no_parity    = no_parity_r;
  assign ev_parity    = ev_parity_r;

  // FIFO control: a push into a full FIFO only lands when a pop frees the head slot.
  always_comb begin
    push_s    = (state_r == ST_CAPTURE) & cfg_en;
    pop_s     = rd.rd_req & (cnt_r != 3'd0);
    full_s    = (cnt_r == 3'd4);
    wr_s      = push_s & (~full_s | pop_s);
    ovr_set_s = push_s & full_s & ~pop_s;
    if (wr_s && !pop_s) begin
      cnt_nxt_s = cnt_r + 3'd1;
    end else if (pop_s && !wr_s) begin
      cnt_nxt_s = cnt_r - 3'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Effective level threshold, clamped into 1..4.
  always_comb begin
    case (cfg_thresh)
      3'd0:    thr_s = 3'd1;
      3'd1:    thr_s = 3'd1;
      3'd2:    thr_s = 3'd2;
      3'd3:    thr_s = 3'd3;
      3'd4:    thr_s = 3'd4;
      default: thr_s = 3'd4;
    endcase
  end

  // FIFO storage; pointers and count carry the reset, so the array needs none.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= {rx_perr, rx_byte};
    end
  end

  // FIFO pointers, occupancy, sticky overrun and level interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= 2'd0;
      rd_ptr_r  <= 2'd0;
      cnt_r     <= 3'd0;
      ovr_r     <= 1'b0;
      irq_lvl_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      cnt_r     <= cnt_nxt_s;
      irq_lvl_r <= (cnt_nxt_s >= thr_s);
      if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr) begin
        ovr_r <= 1'b0;
      end
    end
  end

  assign rd.rd_valid = (cnt_r != 3'd0);
  assign rd.rd_data  = (cnt_r != 3'd0) ? mem_r[rd_ptr_r] : 9'h000;
  assign fifo_cnt    = cnt_r;
  assign ovr         = ovr_r;
  assign irq_lvl     = irq_lvl_r;

`ifdef UX607_UART_RX_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'd640;

  logic [9:0] tmo_cnt_r;
  logic [9:0] tmo_nxt_s;
  logic       irq_tmo_r;

  // Idle-time counter: any FIFO activity or an empty FIFO restarts it; it saturates at the limit.
  always_comb begin
    if (push_s || pop_s || (cnt_r == 3'd0)) begin
      tmo_nxt_s = 10'd0;
    end else if (sample_s && (tmo_cnt_r != TMO_LIMIT)) begin
      tmo_nxt_s = tmo_cnt_r + 10'd1;
    end else begin
      tmo_nxt_s = tmo_cnt_r;
    end
  end

  // Timeout counter and its interrupt flag update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= 10'd0;
      irq_tmo_r <= 1'b0;
    end else begin
      tmo_cnt_r <= tmo_nxt_s;
      irq_tmo_r <= (tmo_nxt_s == TMO_LIMIT);
    end
  end

  assign irq_tmo = irq_tmo_r;
`else
  assign irq_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_ux607_uart0_rx_ctrl.sv
// Directed bench for ux607_uart0_rx_ctrl: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ux607_uart0_rx_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic        cfg_no_parity;
  logic        cfg_ev_parity;
  logic [15:0] cfg_div;
  logic [2:0]  cfg_thresh;
  logic        rx_ok;
  logic [7:0]  rx_byte;
  logic        rx_perr;
  logic        rx_en;
  logic        rx_data_sample;
  logic        no_parity;
  logic        ev_parity;
  logic        rd_data_flag;
  logic [2:0]  fifo_cnt;
  logic        ovr;
  logic        ovr_clr;
  logic        irq_lvl;
  logic        irq_tmo;

  ux607_uart0_rx_ctrl_if rd_if ();

  ux607_uart0_rx_ctrl dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_no_parity(cfg_no_parity),
    .cfg_ev_parity(cfg_ev_parity), .cfg_div(cfg_div), .cfg_thresh(cfg_thresh),
    .rx_ok(rx_ok), .rx_byte(rx_byte), .rx_perr(rx_perr), .rx_en(rx_en),
    .rx_data_sample(rx_data_sample), .no_parity(no_parity), .ev_parity(ev_parity),
    .rd_data_flag(rd_data_flag), .rd(rd_if), .fifo_cnt(fifo_cnt), .ovr(ovr),
    .ovr_clr(ovr_clr), .irq_lvl(irq_lvl), .irq_tmo(irq_tmo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  bit chk_on = 1'b0;

  // Reference model state, described in terms of rx_ok high periods and a byte queue.
  int         k = 0;           // enabled cycles since the tick counter was last parked
  bit         m_active = 1'b0; // receiver enabled
  bit         m_armed = 1'b0;  // waiting for a new rx_ok high period
  bit         m_pend = 1'b0;   // capture cycle in progress
  bit         m_np = 1'b0;
  bit         m_ep = 1'b0;
  bit         m_ovr = 1'b0;
  bit         m_irq = 1'b0;
  int         m_tmo = 0;
  logic [8:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_thr(input logic [2:0] t);
    if (t == 3'd0) return 1;
    if (t > 3'd4) return 4;
    return int'(t);
  endfunction

  function automatic bit exp_sample();
    return cfg_en && !rst && ((k % (int'(cfg_div) + 1)) == int'(cfg_div));
  endfunction

  task automatic model_step();
    bit samp;
    bit push;
    bit pop;
    int sz;
    samp = exp_sample();
    sz   = q.size();
    pop  = rd_if.rd_req && (sz > 0);
    push = m_pend && cfg_en && !rst;
    if (rst) begin
      q.delete();
      m_ovr = 0; m_irq = 0; m_tmo = 0; m_np = 0; m_ep = 0;
      m_active = 0; m_armed = 0; m_pend = 0; k = 0;
    end else begin
      if (push && !pop && sz == 4) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
      if (pop) void'(q.pop_front());
      if (push && (sz < 4 || pop)) q.push_back({rx_perr, rx_byte});
      m_irq = (q.size() >= eff_thr(cfg_thresh));
      if (push || pop || sz == 0) m_tmo = 0;
      else if (samp && m_tmo < 640) m_tmo++;
      if (!m_active) begin
        m_np = cfg_no_parity;
        m_ep = cfg_ev_parity;
      end
      k = cfg_en ? k + 1 : 0;
      if (!cfg_en) begin
        m_active = 0; m_armed = 0; m_pend = 0;
      end else if (!m_active) begin
        m_active = 1; m_armed = 1;
      end else if (m_pend) begin
        m_pend = 0;
      end else if (m_armed && rx_ok) begin
        m_pend = 1; m_armed = 0;
      end else if (!m_armed && !rx_ok) begin
        m_armed = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model, half a cycle after the edge.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("rx_en", rx_en, m_active);
      check("rx_data_sample", rx_data_sample, exp_sample());
      if (rx_data_sample === 1'b1) pulse_cnt++;
      check("rd_data_flag", rd_data_flag, m_pend);
      check("no_parity", no_parity, m_np);
      check("ev_parity", ev_parity, m_ep);
      check("fifo_cnt", fifo_cnt, 32'(q.size()));
      check("rd_valid", rd_if.rd_valid, q.size() > 0);
      check("rd_data", rd_if.rd_data, (q.size() > 0) ? 32'(q[0]) : 32'd0);
      check("ovr", ovr, m_ovr);
      check("irq_lvl", irq_lvl, m_irq);
`ifdef UX607_UART_RX_TIMEOUT_EN
      check("irq_tmo", irq_tmo, m_tmo == 640);
`else
      check("irq_tmo", irq_tmo, 1'b0);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic capture(input logic [7:0] b, input logic p, input int hi);
    rx_byte = b;
    rx_perr = p;
    rx_ok   = 1'b1;
    step(hi);
    rx_ok   = 1'b0;
    step(3);
  endtask

  task automatic pop1();
    rd_if.rd_req = 1'b1;
    step(1);
    rd_if.rd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_no_parity = 1'b0; cfg_ev_parity = 1'b0;
    cfg_div = 16'd3; cfg_thresh = 3'd2; rx_ok = 1'b0; rx_byte = 8'h00;
    rx_perr = 1'b0; ovr_clr = 1'b0; rd_if.rd_req = 1'b0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    step(2);
    check("reset fifo_cnt", fifo_cnt, 3'd0);
    check("reset rd_data", rd_if.rd_data, 9'h000);
    check("reset rx_en", rx_en, 1'b0);

    // Tick generator and parity latch
    rst = 1'b0; cfg_no_parity = 1'b1; cfg_ev_parity = 1'b1; cfg_en = 1'b1;
    pulse_cnt = 0;
    step(16);
    check("tick pulses div3", pulse_cnt, 4);
    check("no_parity loaded", no_parity, 1'b1);
    cfg_no_parity = 1'b0;
    step(2);
    check("no_parity frozen", no_parity, 1'b1);
    cfg_en = 1'b0;
    pulse_cnt = 0;
    step(8);
    check("tick pulses disabled", pulse_cnt, 0);
    check("no_parity reload in OFF", no_parity, 1'b0);

    // Single capture latency, then threshold 2
    cfg_ev_parity = 1'b0; cfg_thresh = 3'd2; cfg_en = 1'b1;
    step(2);
    rx_byte = 8'hA5; rx_perr = 1'b1; rx_ok = 1'b1;
    step(1);
    check("capture flag", rd_data_flag, 1'b1);
    check("cnt before push", fifo_cnt, 3'd0);
    step(1);
    check("cnt after push", fifo_cnt, 3'd1);
    check("rd_data A5", rd_if.rd_data, 9'h1A5);
    check("irq_lvl thr2 at 1", irq_lvl, 1'b0);
    step(18);
    check("one push per high", fifo_cnt, 3'd1);
    rx_ok = 1'b0;
    step(3);
    capture(8'h3C, 1'b0, 4);
    check("irq_lvl thr2 at 2", irq_lvl, 1'b1);
    check("head still A5", rd_if.rd_data, 9'h1A5);
    pop1();
    check("second entry", rd_if.rd_data, 9'h03C);
    pop1();
    rd_if.rd_req = 1'b1;
    step(1);
    rd_if.rd_req = 1'b0;
    check("pop empty ignored", fifo_cnt, 3'd0);

    // Threshold 0 acts as 1
    cfg_thresh = 3'd0;
    capture(8'h77, 1'b0, 4);
    check("irq_lvl thr0 at 1", irq_lvl, 1'b1);
    pop1();
    check("irq_lvl thr0 at 0", irq_lvl, 1'b0);

    // Overrun: five bytes, no reads
    cfg_thresh = 3'd7;
    for (int i = 1; i <= 5; i++) capture(8'(i), 1'b0, 4);
    check("full cnt", fifo_cnt, 3'd4);
    check("ovr set", ovr, 1'b1);
    check("irq_lvl thr7 full", irq_lvl, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("ovr pop order", rd_if.rd_data, 9'(i));
      pop1();
    end
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    check("ovr cleared", ovr, 1'b0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) capture(8'h10 + 8'(i), 1'b0, 4);
    rx_byte = 8'h14; rx_ok = 1'b1;
    step(1);
    rd_if.rd_req = 1'b1;
    step(1);
    rd_if.rd_req = 1'b0;
    check("full push+pop cnt", fifo_cnt, 3'd4);
    check("full push+pop ovr", ovr, 1'b0);
    check("full push+pop head", rd_if.rd_data, 9'h011);
    rx_ok = 1'b0;
    step(3);
    for (int i = 1; i <= 4; i++) begin
      check("drain order", rd_if.rd_data, 9'h010 + 9'(i));
      pop1();
    end

    // Disable during the capture cycle drops the byte
    rx_byte = 8'hEE; rx_ok = 1'b1;
    step(1);
    cfg_en = 1'b0;
    step(1);
    check("disable in capture cnt", fifo_cnt, 3'd0);
    check("disable in capture rx_en", rx_en, 1'b0);
    rx_ok = 1'b0; cfg_en = 1'b1;
    step(2);

    // Reset mid-capture
    capture(8'h21, 1'b0, 4);
    rx_byte = 8'h22; rx_ok = 1'b1;
    step(1);
    rst = 1'b1; rx_ok = 1'b0;
    step(1);
    check("rx_en in reset", rx_en, 1'b0);
    rst = 1'b0;
    step(1);
    check("resume after reset", rx_en, 1'b1);
    check("reset flushed", fifo_cnt, 3'd0);

    // Reads continue while disabled
    capture(8'h5A, 1'b1, 4);
    cfg_en = 1'b0;
    step(2);
    check("read in OFF valid", rd_if.rd_valid, 1'b1);
    check("read in OFF data", rd_if.rd_data, 9'h15A);
    pop1();
    check("read in OFF empty", fifo_cnt, 3'd0);

    // Timeout with one tick per clock
    cfg_div = 16'd0; cfg_en = 1'b1;
    step(2);
    capture(8'h66, 1'b0, 4);
    step(700);
`ifdef UX607_UART_RX_TIMEOUT_EN
    check("irq_tmo after idle", irq_tmo, 1'b1);
`else
    check("irq_tmo absent", irq_tmo, 1'b0);
`endif
    pop1();
    check("irq_tmo after pop", irq_tmo, 1'b0);
    step(2);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ux607_uart0_rx_ctrl.md
UX607_UART0_RX_CTRL -- requirements
Module: ux607_uart0_rx_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; all flops update on posedge clk only.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 cfg_en  in  1  receiver enable.
REQ-005 cfg_no_parity  in  1  1 = no parity bit; cfg_ev_parity  in  1  1 = even parity, 0 = odd parity.
REQ-006 cfg_div  in  16  sample-tick divisor; one tick every cfg_div+1 clocks.
REQ-007 cfg_thresh  in  3  FIFO-level interrupt threshold; 0 is treated as 1, values above 4 are treated as 4.
REQ-008 rx_ok  in  1  receiver stop-state level (high for the whole stop phase).
REQ-009 rx_byte  in  8  receiver data, valid while rd_data_flag=1; rx_perr  in  1  receiver parity error.
REQ-010 rx_en, rx_data_sample, no_parity, ev_parity, rd_data_flag  out  1 each  receiver controls.
REQ-011 rd_req  in  1  pop request; rd_data  out  9  {perr, byte} at FIFO head; rd_valid  out  1  FIFO non-empty.
REQ-012 fifo_cnt  out  3  entries 0..4; ovr  out  1  sticky overrun; ovr_clr  in  1  clears ovr.
REQ-013 irq_lvl  out  1  level interrupt; irq_tmo  out  1  timeout interrupt.

Function
REQ-014 Tick generator: 16-bit counter runs while cfg_en=1; rx_data_sample is a 1-clock pulse when counter==cfg_div, and the counter then wraps to 0; while cfg_en=0 the counter is held at 0 and no pulse is emitted.
REQ-015 FSM states: OFF, WAIT_OK, CAPTURE, WAIT_CLR; rx_en = (state != OFF).
REQ-016 Transitions:
  - OFF->WAIT_OK when cfg_en=1.
  - WAIT_OK->CAPTURE when rx_ok=1.
  - CAPTURE->WAIT_CLR unconditionally.
  - WAIT_CLR->WAIT_OK when rx_ok=0.
  - Any state->OFF when cfg_en=0, with priority over all other transitions.
REQ-017 no_parity/ev_parity are registered copies of cfg_no_parity/cfg_ev_parity, loaded only while in OFF and frozen otherwise.
REQ-018 rd_data_flag=1 only in CAPTURE; the FIFO push of {rx_perr, rx_byte} occurs in that same cycle.
REQ-019 Capture latency: rx_ok rises in cycle N -> push at end of N+1 -> fifo_cnt/rd_valid updated in N+2; exactly one push per rx_ok high period.
REQ-020 If cfg_en falls while in CAPTURE, the state goes to OFF and no push occurs.
REQ-021 FIFO: 4 entries x 9 bits, circular; 2-bit pointers wrap 3->0.
REQ-022 rd_data is combinational from the head entry, and is 9'h000 when empty; pop occurs when rd_req=1 and rd_valid=1; rd_req while empty is ignored.
REQ-023 Push and pop in the same cycle: both take effect, fifo_cnt is unchanged, and this is not an overrun even when full.
REQ-024 Push while full without pop: the byte is dropped, FIFO contents are unchanged, and ovr is set 1 the next cycle.
REQ-025 ovr_clr=1 clears ovr; a simultaneous overrun set wins over the clear.
REQ-026 irq_lvl = (fifo_cnt >= effective threshold), registered, so it lags fifo_cnt by 0 cycles (same flop update).
REQ-027 cfg_en=0 does not flush the FIFO; reads continue to work while in OFF.

Reset
REQ-028 rst=1 SHALL force:
  - state OFF; tick counter 0; FIFO pointers and fifo_cnt 0.
  - rx_en, rx_data_sample, rd_data_flag, rd_valid, ovr, irq_lvl, irq_tmo all 0.
  - no_parity=0, ev_parity=0, rd_data=9'h000.
REQ-029 Reset mid-frame or mid-CAPTURE discards the in-flight byte; the controller resumes at WAIT_OK the cycle after rst falls, provided cfg_en=1.

Configuration
REQ-030 With macro UX607_UART_RX_TIMEOUT_EN defined, the timeout counter is compiled in:
  - a 10-bit counter increments on each rx_data_sample while fifo_cnt != 0;
  - it clears on any push, on any pop, or when fifo_cnt = 0;
  - irq_tmo = 1 when the count reaches 640 and holds until a clear condition occurs; the counter saturates at 640.
REQ-031 Without UX607_UART_RX_TIMEOUT_EN, no timeout logic is present; irq_tmo is tied 0 and the port still exists.

Verification
REQ-032 cfg_div=3, cfg_en=1 -> rx_data_sample pulses every 4th clock; cfg_en=0 -> no pulses and counter at 0.
REQ-033 rx_ok high for 20 clocks with rx_byte=8'hA5, rx_perr=1 -> exactly one push, rd_data=9'h1A5, fifo_cnt=1 two cycles after the rx_ok rise.
REQ-034 Five bytes 01..05 with no reads -> fifo_cnt=4, ovr=1, pops return 01,02,03,04; ovr_clr -> ovr=0.
REQ-035 FIFO full, rx_ok capture with rd_req=1 in the CAPTURE cycle -> fifo_cnt stays 4, ovr stays 0, head advances.
REQ-036 cfg_thresh=2 -> irq_lvl=0 at 1 entry, 1 at 2 entries; cfg_thresh=0 -> irq_lvl=1 at 1 entry.
REQ-037 With UX607_UART_RX_TIMEOUT_EN: 1 entry, cfg_div=0, no activity -> irq_tmo=1 after 640 ticks; a pop clears it; without the macro irq_tmo stays 0.
